// File: rtl/btb_predictor_pkg.sv
// Shared constants and PC slicing helpers for the branch target buffer.
// Optional feature macro used across the slice: BTB_PERF_CNT_EN.
`ifndef BTB_PREDICTOR_PKG_SV
`define BTB_PREDICTOR_PKG_SV

// Index is the word address modulo the table size; tag is everything above it.
`define BTB_IDX(pc, iw) pc[(iw)+1:2]
`define BTB_TAG(pc, iw) pc[31:(iw)+2]

package btb_predictor_pkg;
    localparam int BTB_ENTRIES = 16;

    localparam logic [1:0] CTR_SNT = 2'd0;
    localparam logic [1:0] CTR_WNT = 2'd1;
    localparam logic [1:0] CTR_WT  = 2'd2;
    localparam logic [1:0] CTR_ST  = 2'd3;
endpackage

`endif

// File: rtl/btb_predictor_if.sv
// Fetch lookup, execute training and (with BTB_PERF_CNT_EN) perf counter signals.
// upd_en is a one-cycle valid qualifier with no ready: the BTB always accepts training.
interface btb_predictor_if;
    logic [31:0] if_pc;
    logic        predicted_taken;
    logic [31:0] predicted_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_is_jump;
    logic        upd_mispredict;
    logic        invalidate;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_updates;
    logic [31:0] perf_mispredicts;
`endif

    modport master (
        output if_pc, upd_en, upd_pc, upd_target, upd_taken, upd_is_jump,
               upd_mispredict, invalidate,
`ifdef BTB_PERF_CNT_EN
        input  perf_lookups, perf_updates, perf_mispredicts,
`endif
        input  predicted_taken, predicted_target
    );

    modport slave (
        input  if_pc, upd_en, upd_pc, upd_target, upd_taken, upd_is_jump,
               upd_mispredict, invalidate,
`ifdef BTB_PERF_CNT_EN
        output perf_lookups, perf_updates, perf_mispredicts,
`endif
        output predicted_taken, predicted_target
    );
endinterface

// File: rtl/btb_sat_ctr.sv
// Next-state function of a 2-bit saturating up/down direction counter.
module btb_sat_ctr
    import btb_predictor_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_nxt
);
    always_comb begin
        ctr_nxt = ctr;
        if (taken) begin
            if (ctr != CTR_ST) ctr_nxt = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_nxt = ctr - 2'd1;
        end
    end
endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup, edge-trained.
// Define BTB_PERF_CNT_EN to add lookup/update/mispredict performance counters.
module btb_predictor
    import btb_predictor_pkg::*;
#(
    parameter int ENTRIES = BTB_ENTRIES
) (
    input  logic            clk,
    input  logic            rst_n,
    btb_predictor_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [IDX_W-1:0] rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_hit;
    logic [IDX_W-1:0] wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit;
    logic [1:0]       ctr_nxt;
    logic             train;

    assign rd_idx = `BTB_IDX(bus.if_pc, IDX_W);
    assign rd_tag = `BTB_TAG(bus.if_pc, IDX_W);
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    // Pure read of current contents: a same-index write shows up only next cycle.
    assign bus.predicted_taken  = rd_hit && ctr_q[rd_idx][1];
    assign bus.predicted_target = bus.predicted_taken ? target_q[rd_idx]
                                                      : bus.if_pc + 32'd4;

    assign wr_idx = `BTB_IDX(bus.upd_pc, IDX_W);
    assign wr_tag = `BTB_TAG(bus.upd_pc, IDX_W);
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign train  = rst_n && !bus.invalidate && bus.upd_en;

    btb_sat_ctr u_sat_ctr (
        .ctr     (ctr_q[wr_idx]),
        .taken   (bus.upd_taken),
        .ctr_nxt (ctr_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || bus.invalidate) begin
            valid_q <= '0;
        end else if (bus.upd_en && !wr_hit && (bus.upd_taken || bus.upd_is_jump)) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Payload arrays carry no reset; valid_q alone decides whether they are trusted.
    always_ff @(posedge clk) begin
        if (train) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= bus.upd_is_jump ? CTR_ST : ctr_nxt;
                if (bus.upd_taken || bus.upd_is_jump) target_q[wr_idx] <= bus.upd_target;
            end else if (bus.upd_taken || bus.upd_is_jump) begin
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= bus.upd_target;
                ctr_q[wr_idx]    <= bus.upd_is_jump ? CTR_ST : CTR_WT;
            end
        end
    end

`ifdef BTB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.perf_lookups     <= '0;
            bus.perf_updates     <= '0;
            bus.perf_mispredicts <= '0;
        end else begin
            bus.perf_lookups <= bus.perf_lookups + 32'd1;
            if (bus.upd_en) bus.perf_updates <= bus.perf_updates + 32'd1;
            if (bus.upd_en && bus.upd_mispredict)
                bus.perf_mispredicts <= bus.perf_mispredicts + 32'd1;
        end
    end

    logic [1:0] unused_bits;
    assign unused_bits = bus.upd_pc[1:0];
`else
    logic [2:0] unused_bits;
    assign unused_bits = {bus.upd_pc[1:0], bus.upd_mispredict};
`endif
endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor: reset, allocation, counter hysteresis, aliasing,
// same-cycle read/write, invalidate priority and (with BTB_PERF_CNT_EN) perf counters.
module tb_btb_predictor;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    int unsigned exp_lookups;
    int unsigned exp_updates;
    int unsigned exp_misp;

    btb_predictor_if bus ();

    btb_predictor dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_upd();
        bus.upd_en         = 1'b0;
        bus.upd_pc         = 32'h0;
        bus.upd_target     = 32'h0;
        bus.upd_taken      = 1'b0;
        bus.upd_is_jump    = 1'b0;
        bus.upd_mispredict = 1'b0;
        bus.invalidate     = 1'b0;
    endtask

    // Advance one edge; the perf model follows what the edge should do.
    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            exp_lookups = 0;
            exp_updates = 0;
            exp_misp    = 0;
        end else begin
            exp_lookups++;
            if (bus.upd_en) exp_updates++;
            if (bus.upd_en && bus.upd_mispredict) exp_misp++;
        end
        #1;
    endtask

    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic taken, input logic jump, input logic misp);
        bus.upd_en         = 1'b1;
        bus.upd_pc         = pc;
        bus.upd_target     = tgt;
        bus.upd_taken      = taken;
        bus.upd_is_jump    = jump;
        bus.upd_mispredict = misp;
        tick();
        idle_upd();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic exp_taken, input logic [31:0] exp_tgt);
        bus.if_pc = pc;
        #1;
        check({tag, "_taken"}, {31'd0, bus.predicted_taken}, {31'd0, exp_taken});
        check({tag, "_target"}, bus.predicted_target, exp_tgt);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_lookups = 0;
        exp_updates = 0;
        exp_misp    = 0;
        idle_upd();
        bus.if_pc = 32'h100;
        rst_n = 1'b0;
        tick();
        tick();
        look("reset", 32'h100, 1'b0, 32'h104);
        rst_n = 1'b1;

        // Allocate conditional taken at 0x100 -> ctr=2
        train(32'h100, 32'h80, 1'b1, 1'b0, 1'b1);
        look("alloc", 32'h100, 1'b1, 32'h80);

        // Hysteresis down: 2 -> 1 -> 0
        train(32'h100, 32'h0, 1'b0, 1'b0, 1'b1);
        look("nt1", 32'h100, 1'b0, 32'h104);
        train(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        look("nt2", 32'h100, 1'b0, 32'h104);

        // Hysteresis up: 0 -> 1 -> 2 -> 3 -> 3
        train(32'h100, 32'h90, 1'b1, 1'b0, 1'b1);
        look("t1", 32'h100, 1'b0, 32'h104);
        train(32'h100, 32'hA0, 1'b1, 1'b0, 1'b0);
        look("t2", 32'h100, 1'b1, 32'hA0);
        train(32'h100, 32'hB0, 1'b1, 1'b0, 1'b0);
        look("t3", 32'h100, 1'b1, 32'hB0);
        train(32'h100, 32'hC0, 1'b1, 1'b0, 1'b0);
        look("t4_sat", 32'h100, 1'b1, 32'hC0);
        // Saturated at 3: one not-taken leaves it weakly taken, target kept
        train(32'h100, 32'hDEAD, 1'b0, 1'b0, 1'b1);
        look("sat_nt1", 32'h100, 1'b1, 32'hC0);
        train(32'h100, 32'hDEAD, 1'b0, 1'b0, 1'b0);
        look("sat_nt2", 32'h100, 1'b0, 32'h104);

        // Alias at index 0: 0x140 evicts 0x100
        train(32'h140, 32'h300, 1'b1, 1'b0, 1'b1);
        look("evicted", 32'h100, 1'b0, 32'h104);
        look("alias_new", 32'h140, 1'b1, 32'h300);
        train(32'h180, 32'h700, 1'b0, 1'b0, 1'b0);
        look("nt_miss_keep", 32'h140, 1'b1, 32'h300);
        look("nt_miss_none", 32'h180, 1'b0, 32'h184);

        // Hit jump forces ctr=3 and new target; one not-taken still predicts taken
        train(32'h140, 32'h400, 1'b1, 1'b1, 1'b0);
        train(32'h140, 32'h0, 1'b0, 1'b0, 1'b0);
        look("hit_jump", 32'h140, 1'b1, 32'h400);

        // Jump miss allocates with ctr=3
        train(32'h24, 32'h1000, 1'b1, 1'b1, 1'b1);
        train(32'h24, 32'h0, 1'b0, 1'b0, 1'b0);
        look("jump_alloc", 32'h24, 1'b1, 32'h1000);

        // Same-cycle read/write at 0x200: no bypass
        bus.if_pc          = 32'h200;
        bus.upd_en         = 1'b1;
        bus.upd_pc         = 32'h200;
        bus.upd_target     = 32'h500;
        bus.upd_taken      = 1'b1;
        #1;
        check("rw_same_taken", {31'd0, bus.predicted_taken}, 32'd0);
        check("rw_same_target", bus.predicted_target, 32'h204);
        tick();
        idle_upd();
        look("rw_next", 32'h200, 1'b1, 32'h500);

        // PC+4 wraps at 2^32
        look("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Invalidate wins over a concurrent allocation
        bus.invalidate     = 1'b1;
        bus.upd_en         = 1'b1;
        bus.upd_pc         = 32'h3C;
        bus.upd_target     = 32'h900;
        bus.upd_taken      = 1'b1;
        bus.upd_mispredict = 1'b1;
        tick();
        idle_upd();
        look("inv_drop", 32'h3C, 1'b0, 32'h40);
        look("inv_200", 32'h200, 1'b0, 32'h204);
        look("inv_140", 32'h140, 1'b0, 32'h144);
        look("inv_24", 32'h24, 1'b0, 32'h28);

        // Stale tag/ctr survive invalidate but must not be trusted or reused
        train(32'h24, 32'h0, 1'b0, 1'b0, 1'b0);
        look("inv_nt_miss", 32'h24, 1'b0, 32'h28);
        train(32'h24, 32'h2000, 1'b1, 1'b0, 1'b0);
        train(32'h24, 32'h0, 1'b0, 1'b0, 1'b0);
        look("realloc_wt", 32'h24, 1'b0, 32'h28);

`ifdef BTB_PERF_CNT_EN
        check("perf_lookups", bus.perf_lookups, exp_lookups);
        check("perf_updates", bus.perf_updates, exp_updates);
        check("perf_mispredicts", bus.perf_mispredicts, exp_misp);
`endif

        // Reset asserted during training drops the update
        bus.if_pc  = 32'h44;
        rst_n      = 1'b0;
        bus.upd_en = 1'b1;
        bus.upd_pc = 32'h44;
        bus.upd_target = 32'hA00;
        bus.upd_taken  = 1'b1;
        tick();
        idle_upd();
        rst_n = 1'b1;
        look("rst_drop", 32'h44, 1'b0, 32'h48);
        look("rst_clear", 32'h140, 1'b0, 32'h144);

`ifdef BTB_PERF_CNT_EN
        check("perf_rst_lookups", bus.perf_lookups, 32'd0);
        tick();
        check("perf_after_rst", bus.perf_lookups, exp_lookups);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Direct-mapped branch target buffer with 2-bit saturating direction counters.
- Fetch stage: looks up the fetch PC combinationally and drives predicted_taken / predicted_target to the PC mux.
- Execute stage: trains on the resolved outcome from the branch/jump resolution logic (update_btb, jump_addr, taken) and produces the predictedTaken bit that travels down the pipe.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, >= 2.
- IDX_W, $clog2(ENTRIES), index width (derived, not overridden).
- TAG_W, 30-IDX_W, tag width taken from pc[31:IDX_W+2].

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- if_pc  in  32  fetch-stage PC to look up.
- predicted_taken  out  1  lookup hit AND counter MSB set.
- predicted_target  out  32  stored target on hit; if_pc+4 otherwise.
- upd_en  in  1  EX-stage branch/jump retires; train this cycle.
- upd_pc  in  32  PC of the resolving instruction.
- upd_target  in  32  resolved jump address.
- upd_taken  in  1  actual outcome (jump or branch taken).
- upd_is_jump  in  1  JAL/JALR (unconditional).
- upd_mispredict  in  1  modify_pc from EX; used only by the perf counters.
- invalidate  in  1  clear all valid bits (fence.i / debug).

Behaviour:
- Storage per entry: valid, tag[TAG_W], target[32], ctr[2]. Index = pc[IDX_W+1:2]. Bits pc[1:0] are ignored.
- Lookup is combinational, zero latency:
  - hit = valid[idx] && tag[idx] == if_pc[31:IDX_W+2].
  - predicted_taken = hit && ctr[1].
  - predicted_target = predicted_taken ? target : if_pc+4 (32-bit wrap).
- Update occurs at the rising edge when upd_en=1:
  - Hit, conditional branch: ctr increments (saturating at 3) if taken, else decrements (saturating at 0). When taken, target <= upd_target.
  - Hit, jump: ctr <= 3, target <= upd_target.
  - Miss, taken: allocate (replace) the entry. valid=1, tag, target; ctr = 3 for a jump, else 2 (weakly taken).
  - Miss, not taken: no write.
- Read/write same index in the same cycle: lookup returns pre-update contents; there is no bypass.
- invalidate=1: all valid bits clear at the edge. It has priority over a concurrent upd_en, which is dropped. Tag, target and ctr are not cleared.
- Reset (rst_n=0 at the edge): all valid bits clear. Reset asserted mid-training drops that update.
  - Outputs after reset: predicted_taken=0, predicted_target=if_pc+4.
  - Tag, target and ctr arrays need not reset.
- The entry array has no internal FSM. Storage is flops, or distributed RAM with an asynchronous read port.

Optional Feature:
- Macro: BTB_PERF_CNT_EN.
- When defined, adds three 32-bit outputs, all synchronously reset to 0 and wrapping at 2^32:
  - perf_lookups: increments every cycle rst_n=1.
  - perf_updates: increments on each upd_en.
  - perf_mispredicts: increments on upd_en && upd_mispredict.
- invalidate does not clear the counters.
- When not defined: the ports and logic are absent, and the module behaves exactly as above.

Decomposition:
- Shared package/defines:
  - counter encoding constants: CTR_SNT=0, CTR_WNT=1, CTR_WT=2, CTR_ST=3.
  - BTB_ENTRIES default.
  - index/tag slicing macros.
- Sub-module btb_sat_ctr: 2-bit saturating up/down counter next-state function.
- Array and hit logic stay in the top module.

Test Plan:
- Reset then lookup: rst_n=0 for 2 cycles, if_pc=0x100 -> predicted_taken=0, predicted_target=0x104.
- Allocate and hit: upd_en with upd_pc=0x100, target=0x80, taken=1, is_jump=0; next cycle if_pc=0x100 -> taken=1, target=0x80, ctr=2.
- Counter hysteresis:
  - From ctr=2, two not-taken updates at 0x100 -> ctr 1 then 0; predicted_taken=0 after the first.
  - Three taken updates -> ctr 1, 2, 3; stays 3 on a fourth.
- Alias/replace:
  - ENTRIES=16: a taken update at 0x140 evicts 0x100 (same index 0) -> lookup 0x100 misses, returns 0x104.
  - A not-taken miss at 0x180 leaves 0x140 intact.
- Same-cycle read/write: if_pc=0x200 while upd_en allocates 0x200 -> predicted_taken=0 that cycle, 1 the next.
- Invalidate priority: invalidate=1 and upd_en=1 together -> all lookups miss afterwards, no allocation. With BTB_PERF_CNT_EN defined, perf_updates still increments and perf_mispredicts counts upd_mispredict pulses exactly.
